// File: rtl/avalon_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module      : avalon_regbank_slave
// Description : Avalon-MM responder with a 16-bit register bank, programmable
//               wait states and a fixed pipelined read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_regbank_slave #(
  parameter int ADDRSIZE    = 3,
  parameter int DATASIZE    = 16,
  parameter int WAITSTATES  = 1,
  parameter int READLATENCY = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDRSIZE-1:0] address_i,
  input  logic [1:0]          byteenable_i,
  input  logic                read_i,
  input  logic                write_i,
  input  logic [DATASIZE-1:0] writedata_i,
  output logic                waitrequest_o,
  output logic                readdatavalid_o,
  output logic [DATASIZE-1:0] readdata_o
);

  localparam int                  DEPTH       = 2 ** ADDRSIZE;
  localparam logic [DATASIZE-1:0] ID_VALUE    = 16'hCAFE;
  localparam logic [3:0]          WAIT_LIMIT  = 4'(WAITSTATES);
  localparam logic [ADDRSIZE-1:0] ADDR_ID     = ADDRSIZE'(0);
  localparam logic [ADDRSIZE-1:0] ADDR_STATUS = ADDRSIZE'(1);

  logic [3:0]          wcnt;
  logic                req;
  logic                accept;
  logic                wr_accept;
  logic                rd_accept;
  logic                proto_err;
  logic [7:0]          wr_count;
  logic [6:0]          rd_count;
  logic                err_flag;
  logic [DATASIZE-1:0] gp_regs [DEPTH];
  logic [DATASIZE-1:0] read_word;
  logic                gp_target;

  logic [READLATENCY-1:0] pipe_valid;
  logic [DATASIZE-1:0]    pipe_data [READLATENCY];
  logic [DATASIZE-1:0]    hold_data;

  assign req           = read_i | write_i;
  assign waitrequest_o = rst_i | (req & (wcnt != WAIT_LIMIT));
  assign accept        = req & ~waitrequest_o;
  // A simultaneous read+write is serviced as a write only.
  assign wr_accept     = accept & write_i;
  assign rd_accept     = accept & read_i & ~write_i;
  assign proto_err     = accept & read_i & write_i;
  assign gp_target     = (address_i != ADDR_ID) && (address_i != ADDR_STATUS);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wcnt <= 4'd0;
    end else if (!req || accept) begin
      wcnt <= 4'd0;
    end else begin
      wcnt <= wcnt + 4'd1;
    end
  end

  always_comb begin
    read_word = gp_regs[address_i];
    if (address_i == ADDR_ID) begin
      read_word = ID_VALUE;
    end else if (address_i == ADDR_STATUS) begin
      read_word = {err_flag, rd_count, wr_count};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        gp_regs[i] <= '0;
      end
      wr_count <= 8'd0;
      rd_count <= 7'd0;
      err_flag <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_count <= wr_count + 8'd1;
        if (gp_target) begin
          if (byteenable_i[0]) gp_regs[address_i][7:0]  <= writedata_i[7:0];
          if (byteenable_i[1]) gp_regs[address_i][15:8] <= writedata_i[15:8];
        end
        if ((address_i == ADDR_STATUS) && byteenable_i[1] && writedata_i[15]) begin
          err_flag <= 1'b0;
        end
      end
      if (rd_accept) begin
        rd_count <= rd_count + 7'd1;
      end
      // Placed after the W1C clear so a same-cycle error set takes priority.
      if (proto_err) begin
        err_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_valid <= '0;
      for (int i = 0; i < READLATENCY; i++) begin
        pipe_data[i] <= '0;
      end
      hold_data <= '0;
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_data[0]  <= read_word;
      for (int i = 1; i < READLATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      if (pipe_valid[READLATENCY-1]) begin
        hold_data <= pipe_data[READLATENCY-1];
      end
    end
  end

  assign readdatavalid_o = pipe_valid[READLATENCY-1];
  assign readdata_o      = readdatavalid_o ? pipe_data[READLATENCY-1] : hold_data;

endmodule
`default_nettype wire

// File: tb/tb_avalon_regbank_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_avalon_regbank_slave
// Description : Directed, table-driven bench for avalon_regbank_slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_regbank_slave;

  localparam int RL = 2;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          is_read;
    logic [2:0]  addr;
    logic [1:0]  be;
    logic [15:0] data;
    logic [15:0] expv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [2:0]  address = '0;
  logic [1:0]  be = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] wdata = '0;

  logic        read0, write0, read1, write1;
  logic        wreq0, rdv0, wreq1, rdv1;
  logic [15:0] rdata0, rdata1;
  logic        wreq, rdv;
  logic [15:0] rdata;

  // Two instances share one bus; sel steers requests and observed outputs.
  assign read0  = rd & ~sel;
  assign write0 = wr & ~sel;
  assign read1  = rd & sel;
  assign write1 = wr & sel;
  assign wreq   = sel ? wreq1 : wreq0;
  assign rdv    = sel ? rdv1 : rdv0;
  assign rdata  = sel ? rdata1 : rdata0;

  avalon_regbank_slave #(.ADDRSIZE(3), .DATASIZE(16), .WAITSTATES(3), .READLATENCY(RL)) dut_ws3 (
    .clk_i(clk), .rst_i(rst), .address_i(address), .byteenable_i(be),
    .read_i(read0), .write_i(write0), .writedata_i(wdata),
    .waitrequest_o(wreq0), .readdatavalid_o(rdv0), .readdata_o(rdata0)
  );

  avalon_regbank_slave #(.ADDRSIZE(3), .DATASIZE(16), .WAITSTATES(0), .READLATENCY(RL)) dut_ws0 (
    .clk_i(clk), .rst_i(rst), .address_i(address), .byteenable_i(be),
    .read_i(read1), .write_i(write1), .writedata_i(wdata),
    .waitrequest_o(wreq1), .readdatavalid_o(rdv1), .readdata_o(rdata1)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  resp_t rq[$];
  always @(negedge clk) begin
    if (rdv === 1'b1) rq.push_back('{data: rdata, cyc: cycle});
  end

  int errors = 0;
  int checks = 0;
  int exp_wc = 0;
  int exp_rc = 0;
  bit exp_err = 1'b0;

  function automatic logic [15:0] status_model();
    return {exp_err, 7'(exp_rc), 8'(exp_wc)};
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, expv);
    end
  endtask

  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents a request, rides out the stall and returns at acceptance edge + 1.
  task automatic access(input bit r, input bit w, input logic [2:0] a, input logic [1:0] b,
                        input logic [15:0] d, output int stalls, output int acc);
    rd = r; wr = w; address = a; be = b; wdata = d;
    stalls = 0;
    #1;
    while (wreq === 1'b1 && stalls < 40) begin
      @(posedge clk);
      #1;
      stalls++;
    end
    if (wreq !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL access_timeout: waitrequest %b required 0", wreq);
    end
    @(posedge clk);
    #1;
    acc = cycle;
    if (w) exp_wc++;
    else if (r) exp_rc++;
  endtask

  task automatic wait_resp(output resp_t r, output bit ok);
    ok = 1'b0;
    r = '{data: 16'h0, cyc: 0};
    for (int i = 0; i < 12 && !ok; i++) begin
      if (rq.size() > 0) begin
        r = rq.pop_front();
        ok = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: readdatavalid 0 required 1");
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [1:0] b, input logic [15:0] d);
    int st, acc;
    access(1'b0, 1'b1, a, b, d, st, acc);
    idle(0);
  endtask

  // Latency is measured to the cycle whose closing edge samples readdatavalid.
  task automatic do_read(input logic [2:0] a, input logic [15:0] expv, input string name,
                         input int exp_stalls);
    int st, acc;
    resp_t r;
    bit ok;
    access(1'b1, 1'b0, a, 2'b00, 16'h0, st, acc);
    idle(0);
    if (exp_stalls >= 0) chk({name, "_stalls"}, 16'(st), 16'(exp_stalls));
    wait_resp(r, ok);
    if (ok) begin
      chk(name, r.data, expv);
      chk({name, "_lat"}, 16'(r.cyc - acc), 16'(RL - 1));
      chk({name, "_hold"}, rdata, expv);
    end
  endtask

  vec_t vecs[12];

  initial begin
    int st, acc, acc0;
    logic [15:0] e;
    resp_t r0, r1, r2;
    bit ok0, ok1, ok2;

    vecs[0]  = '{1'b0, 3'd3, 2'b11, 16'hFFFF, 16'h0000};
    vecs[1]  = '{1'b0, 3'd3, 2'b10, 16'hAB00, 16'h0000};
    vecs[2]  = '{1'b0, 3'd3, 2'b01, 16'h0012, 16'h0000};
    vecs[3]  = '{1'b1, 3'd3, 2'b00, 16'h0000, 16'hAB12};
    vecs[4]  = '{1'b0, 3'd3, 2'b00, 16'h5555, 16'h0000};
    vecs[5]  = '{1'b1, 3'd3, 2'b00, 16'h0000, 16'hAB12};
    vecs[6]  = '{1'b0, 3'd0, 2'b11, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 3'd0, 2'b00, 16'h0000, 16'hCAFE};
    vecs[8]  = '{1'b0, 3'd7, 2'b11, 16'hA5C3, 16'h0000};
    vecs[9]  = '{1'b1, 3'd7, 2'b00, 16'h0000, 16'hA5C3};
    vecs[10] = '{1'b0, 3'd2, 2'b01, 16'h00EE, 16'h0000};
    vecs[11] = '{1'b1, 3'd2, 2'b00, 16'h0000, 16'h12EE};

    // Reset state with a request pending.
    rd = 1'b1; address = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_waitreq", 16'(wreq), 16'h1);
    chk("rst_rdv", 16'(rdv), 16'h0);
    chk("rst_rdata", rdata, 16'h0000);
    idle(0);
    rst = 1'b0;
    idle(1);

    // Reset while a read is in flight: its response must never appear.
    access(1'b1, 1'b0, 3'd2, 2'b00, 16'h0, st, acc);
    idle(0);
    rst = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_no_resp", 16'(rq.size()), 16'h0);
    rst = 1'b0;
    rq.delete();
    exp_wc = 0; exp_rc = 0; exp_err = 1'b0;
    idle(1);

    do_read(3'd1, 16'h0000, "post_rst_status", 3);
    do_read(3'd0, 16'hCAFE, "post_rst_id", 3);

    access(1'b0, 1'b1, 3'd2, 2'b11, 16'h1234, st, acc);
    idle(0);
    chk("ws3_write_stalls", 16'(st), 16'd3);
    do_read(3'd2, 16'h1234, "ws3_read", 3);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].is_read) do_read(vecs[i].addr, vecs[i].expv, $sformatf("vec%0d", i), 3);
      else do_write(vecs[i].addr, vecs[i].be, vecs[i].data);
    end

    e = status_model();
    do_read(3'd1, e, "status_counts", -1);

    // Simultaneous read+write: write lands, no response, error flag set.
    access(1'b1, 1'b1, 3'd5, 2'b11, 16'h00FF, st, acc);
    exp_err = 1'b1;
    idle(6);
    chk("perr_no_resp", 16'(rq.size()), 16'h0);
    do_read(3'd5, 16'h00FF, "perr_data", -1);
    e = status_model();
    do_read(3'd1, e, "perr_status", -1);
    do_write(3'd1, 2'b10, 16'h8000);
    exp_err = 1'b0;
    e = status_model();
    do_read(3'd1, e, "w1c_status", -1);

    // Error set beats a W1C clear carried by the same access.
    access(1'b1, 1'b1, 3'd1, 2'b10, 16'h8000, st, acc);
    exp_err = 1'b1;
    idle(1);
    e = status_model();
    do_read(3'd1, e, "set_wins_status", -1);
    do_write(3'd1, 2'b10, 16'h8000);
    exp_err = 1'b0;

    // Request dropped mid-stall is never accepted.
    wr = 1'b1; address = 3'd6; be = 2'b11; wdata = 16'hDEAD;
    #1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("drop_stalled", 16'(wreq), 16'h1);
    wr = 1'b0;
    #1;
    chk("drop_wreq_low", 16'(wreq), 16'h0);
    idle(2);
    do_read(3'd6, 16'h0000, "drop_no_write", 3);

    // Write-count wrap over 256 writes; ID untouched by a write.
    e = status_model();
    do_read(3'd1, e, "wrap_pre", -1);
    for (int i = 0; i < 256; i++) do_write(3'd2, 2'b11, 16'(i));
    e = status_model();
    do_read(3'd1, e, "wrap_post", -1);
    do_write(3'd0, 2'b11, 16'h0000);
    do_read(3'd0, 16'hCAFE, "id_after_write", -1);

    // Zero-wait-state instance: back-to-back pipelined reads.
    sel = 1'b1;
    idle(1);
    access(1'b0, 1'b1, 3'd2, 2'b11, 16'h1111, st, acc);
    chk("ws0_stalls", 16'(st), 16'd0);
    access(1'b0, 1'b1, 3'd3, 2'b11, 16'h2222, st, acc);
    access(1'b0, 1'b1, 3'd4, 2'b11, 16'h3333, st, acc);
    access(1'b1, 1'b0, 3'd2, 2'b00, 16'h0, st, acc0);
    access(1'b1, 1'b0, 3'd3, 2'b00, 16'h0, st, acc);
    access(1'b1, 1'b0, 3'd4, 2'b00, 16'h0, st, acc);
    idle(0);
    wait_resp(r0, ok0);
    wait_resp(r1, ok1);
    wait_resp(r2, ok2);
    if (ok0 && ok1 && ok2) begin
      chk("pipe_d0", r0.data, 16'h1111);
      chk("pipe_d1", r1.data, 16'h2222);
      chk("pipe_d2", r2.data, 16'h3333);
      chk("pipe_lat0", 16'(r0.cyc - acc0), 16'(RL - 1));
      chk("pipe_gap1", 16'(r1.cyc - r0.cyc), 16'd1);
      chk("pipe_gap2", 16'(r2.cyc - r1.cyc), 16'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/avalon_regbank_slave.md
Name: avalon_regbank_slave

Overview:
Avalon-MM responder (slave) exposing a small 16-bit register bank. It has programmable wait states on every access and a fixed, pipelined read latency signalled by readdatavalid_o. It is the target-side counterpart of the bench initiator tasks (write, read, byteenable, waitrequest). It is used as a standalone slave inside the Avalon computer and as a reference responder for the DPI-driven benches.

Parameters:
ADDRSIZE, 3, address width; bank holds 2**ADDRSIZE words.
DATASIZE, 16, data width; fixed at 16 (byteenable is 2 bits).
WAITSTATES, 1, stall cycles inserted before each access is accepted (0..15).
READLATENCY, 2, cycles from read acceptance edge to readdatavalid_o (1..8).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
address_i  in  ADDRSIZE  word address
byteenable_i  in  2  bit0 selects [7:0], bit1 selects [15:8]
read_i  in  1  read request
write_i  in  1  write request
writedata_i  in  16  write data
waitrequest_o  out  1  stall; request held until low at a rising edge
readdatavalid_o  out  1  one-cycle pulse, readdata_o valid
readdata_o  out  16  read data

Behaviour:
- Reset is asynchronous and active-high. While rst_i is high, all registers are 0 except ID, the wait counter is 0, the read pipeline is flushed, readdatavalid_o=0, readdata_o=0, and waitrequest_o=1.
- Register map:
  - addr 0: ID, read-only, constant 0xCAFE.
  - addr 1: STATUS. [7:0] accepted-write count (wraps 255->0). [14:8] accepted-read count (wraps 127->0). [15] sticky protocol-error flag.
  - addr 2..2**ADDRSIZE-1: general R/W registers.
- Wait states:
  - Counter wcnt increments each cycle a request is present and stalled. It clears on acceptance and whenever no request is present.
  - Combinational output: waitrequest_o = rst_i | ((read_i|write_i) & (wcnt != WAITSTATES)).
  - Acceptance happens at a rising edge where (read_i|write_i)=1 and waitrequest_o=0.
  - With WAITSTATES=0, every access is accepted in its first cycle.
  - Back-to-back requests: after an acceptance, wcnt=0, so the next request stalls WAITSTATES cycles again.
  - If the master drops the request mid-stall, wcnt clears and nothing is accepted.
- Write acceptance:
  - For each enabled byte lane, the register takes writedata_i in that lane. Disabled lanes are unchanged.
  - byteenable_i=0: no data change, but the write is still counted.
  - Writes to ID are ignored.
  - Write to STATUS: counters are unaffected by the data. writedata_i[15]=1 with byteenable_i[1]=1 clears the error flag (W1C). The write itself still increments the write count.
- Read acceptance:
  - The full 16-bit word is snapshot at the acceptance edge; byteenable_i is ignored.
  - A STATUS read returns the value before this access's own count increment.
  - The snapshot enters a READLATENCY-deep shift pipeline. readdatavalid_o is high for exactly one cycle, READLATENCY cycles after the acceptance edge, with readdata_o equal to the snapshot.
  - readdata_o holds its last delivered value between pulses.
  - Up to READLATENCY reads are outstanding. Responses come back in order, one per cycle, with no bubbles beyond those in the request stream.
- Simultaneous read_i and write_i:
  - Treated as a write; the read is discarded.
  - STATUS[15] is set at the acceptance edge, and only the write count increments.
  - If the same cycle also carries a W1C write to STATUS, the set wins.
- Read-after-write to the same address on consecutive acceptances returns the new data, since the write commits at its acceptance edge.
- Reset mid-operation: all in-flight responses are lost and no readdatavalid_o is emitted for them. After reset deasserts, the first request stalls the full WAITSTATES.

Test Plan:
- Reset check. Assert rst_i mid-read with READLATENCY=2. Required: readdatavalid_o never pulses for that read. After release, read addr0 returns 0xCAFE, and addr1 returns 0x0000 (the status read's own increment applies only after its snapshot).
- Wait states, WAITSTATES=3. Hold write addr2 data 0x1234 be=3. Required: waitrequest_o=1 for exactly 3 cycles, then accepted. Reading addr2 returns 0x1234, with readdatavalid_o exactly 2 cycles after the read acceptance.
- Byte lanes. After addr3=0xFFFF, write 0xAB00 be=2, then 0x0012 be=1. Required: read addr3=0xAB12. Writing 0x5555 be=0 leaves addr3=0xAB12.
- Pipelined reads, WAITSTATES=0, READLATENCY=2. Issue reads addr2, addr3, addr4 on 3 consecutive cycles. Required: 3 consecutive readdatavalid_o pulses in order with the matching data.
- Protocol error. Assert read_i and write_i together to addr5 with 0x00FF. Required: addr5=0x00FF, no read response, and STATUS[15]=1. Then write 0x8000 be=2 to addr1. Required: STATUS[15]=0 and the write count incremented.
- Counter wrap. Perform 256 writes to addr2. Required: STATUS[7:0] returns to its pre-test value, and ID is unchanged after a write of 0x0000 to addr0.
